// File: rtl/colparity_pkg.sv
// Shared constants, mode encoding, FSM states and the per-slice column-parity
// helper for the column-parity engine.
package colparity_pkg;

  localparam int SLICE_W = 25;
  localparam int LANES   = 5;

  typedef enum logic {
    THETA  = 1'b0,
    BYPASS = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    LOAD,
    PREP,
    EMIT
  } state_e;

  // C[x] = XOR over y of slice bit (x + 5*y)
  function automatic logic [LANES-1:0] col_parity(input logic [SLICE_W-1:0] s);
    logic [LANES-1:0] c;
    c = '0;
    for (int x = 0; x < LANES; x++) begin
      for (int y = 0; y < LANES; y++) begin
        c[x] = c[x] ^ s[x + LANES*y];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/slice_theta.sv
// Combinational per-slice transform: theta mixing from the current and previous
// slice column parities, or a straight pass-through in bypass mode.
module slice_theta
  import colparity_pkg::*;
(
  input  logic [SLICE_W-1:0] slice,
  input  logic [LANES-1:0]   c_cur,
  input  logic [LANES-1:0]   c_prev,
  input  logic               mode,
  output logic [SLICE_W-1:0] result
);

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of inferred latches.
    result = slice;
    if (mode == logic'(THETA)) begin
      for (int x = 0; x < LANES; x++) begin
        for (int y = 0; y < LANES; y++) begin
          result[x + LANES*y] = slice[x + LANES*y]
                              ^ c_cur[(x + LANES - 1) % LANES]
                              ^ c_prev[(x + 1) % LANES];
        end
      end
    end
  end

endmodule

// File: rtl/col_parity_engine.sv
// Loads SLICES 25-bit slices, keeps their column parities, then streams out the
// theta-transformed (or bypassed) state one slice per cycle with backpressure.
module col_parity_engine
  import colparity_pkg::*;
#(
  parameter  int SLICES = 64,
  localparam int CNT_W  = $clog2(SLICES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_slice,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic               out_last
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  state_e             state;
  logic [CNT_W-1:0]   z;
  logic               mode_q;
  logic [CNT_W-1:0]   rd_idx;
  logic [CNT_W-1:0]   prev_idx;
  logic [SLICE_W-1:0] result;
  logic               in_hs;
  logic               out_hs;

  logic [SLICE_W-1:0] buf_mem [SLICES];
  logic [LANES-1:0]   par_mem [SLICES];

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Slice whose result is loaded next: 0 from PREP, z+1 from EMIT.
  always_comb begin
    rd_idx = '0;
    if (state == EMIT && z != LAST) begin
      rd_idx = z + CNT_W'(1);
    end
    prev_idx = (rd_idx == '0) ? LAST : rd_idx - CNT_W'(1);
  end

  // NOTE: the slice and parity buffers have no reset; every entry is rewritten in LOAD before EMIT reads it.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_mem[z] <= in_slice;
      par_mem[z] <= col_parity(in_slice);
    end
  end

  slice_theta u_theta (
    .slice  (buf_mem[rd_idx]),
    .c_cur  (par_mem[rd_idx]),
    .c_prev (par_mem[prev_idx]),
    .mode   (mode_q),
    .result (result)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      z         <= '0;
      mode_q    <= THETA;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_slice <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            if (z == '0) begin
              mode_q <= mode;
            end
            if (z == LAST) begin
              z        <= '0;
              in_ready <= 1'b0;
              state    <= PREP;
            end else begin
              z <= z + CNT_W'(1);
            end
          end
        end
        PREP: begin
          out_slice <= result;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_hs) begin
            if (z == LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              z         <= '0;
              in_ready  <= 1'b1;
              state     <= LOAD;
            end else begin
              out_slice <= result;
              out_last  <= (rd_idx == LAST);
              z         <= z + CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= LOAD;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_col_parity_engine.sv
// Scoreboard bench for col_parity_engine: a driver loads states and queues the
// expected output stream; an independent monitor pops and compares on handshakes.
module tb_col_parity_engine;

  localparam int SLICES = 4;

  typedef logic [24:0] state_t [SLICES];
  typedef struct {
    logic [24:0] slice;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_slice = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_slice;
  logic        out_last;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ready_mode = 0;
  int   pat = 0;

  logic        stall = 1'b0;
  logic [24:0] held_slice;
  logic        held_last;

  always #5 clk = ~clk;

  col_parity_engine #(.SLICES(SLICES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_last  (out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: straight from the column-parity definition.
  function automatic logic col_par(input logic [24:0] s, input int x);
    logic p;
    p = 1'b0;
    for (int y = 0; y < 5; y++) p = p ^ s[x + 5*y];
    return p;
  endfunction

  function automatic logic [24:0] ref_out(input state_t st, input int z, input logic byp);
    logic [24:0] r;
    int zp;
    if (byp) return st[z];
    zp = (z + SLICES - 1) % SLICES;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        r[x + 5*y] = st[z][x + 5*y] ^ col_par(st[z], (x + 4) % 5) ^ col_par(st[zp], (x + 1) % 5);
      end
    end
    return r;
  endfunction

  task automatic push_model(input state_t st, input logic byp);
    for (int z = 0; z < SLICES; z++) exp_q.push_back('{ref_out(st, z, byp), (z == SLICES - 1)});
  endtask

  task automatic push_directed(input state_t ex);
    for (int z = 0; z < SLICES; z++) exp_q.push_back('{ex[z], (z == SLICES - 1)});
  endtask

  // Called at posedge+#1; returns at posedge+#1 one edge after out_valid rises.
  task automatic send_state(input state_t st, input logic m);
    bit accepted;
    for (int z = 0; z < SLICES; z++) begin
      in_valid = 1'b1;
      in_slice = st[z];
      mode     = (z == 0) ? m : (m ^ z[0]);
      accepted = 1'b0;
      for (int c = 0; c < 200 && !accepted; c++) begin
        @(negedge clk);
        if (in_ready) accepted = 1'b1;
      end
      if (!accepted) check("in_ready_timeout", 32'(0), 32'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_slice = 25'($urandom);
    mode     = 1'($urandom);
    check("prep_out_valid", 32'(out_valid), 32'(0));
    check("prep_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    check("first_out_valid", 32'(out_valid), 32'(1));
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_state(output state_t st);
    for (int z = 0; z < SLICES; z++) st[z] = 25'($urandom);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pat % 3 == 0);
        pat++;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: the handshake seen at a falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", 32'(out_valid), 32'(1));
        check("stall_slice", 32'(out_slice), 32'(held_slice));
        check("stall_last", 32'(out_last), 32'(held_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_slice), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_slice", 32'(out_slice), 32'(e.slice));
          check("out_last", 32'(out_last), 32'(e.last));
        end
        stall = 1'b0;
      end else if (out_valid) begin
        stall      = 1'b1;
        held_slice = out_slice;
        held_last  = out_last;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t st;
    state_t ex;
    logic   m;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_out_slice", 32'(out_slice), 32'(0));

    // All-zero state
    st = '{25'h0, 25'h0, 25'h0, 25'h0};
    push_directed(st);
    send_state(st, 1'b0);
    wait_drain();

    // Single bit in slice 0
    st = '{25'h0000001, 25'h0, 25'h0, 25'h0};
    ex = '{25'h0210843, 25'h1084210, 25'h0, 25'h0};
    push_directed(ex);
    send_state(st, 1'b0);
    wait_drain();

    // Wrap-around from the last slice into slice 0
    st = '{25'h0, 25'h0, 25'h0, 25'h0000001};
    ex = '{25'h1084210, 25'h0, 25'h0, 25'h0210843};
    push_directed(ex);
    send_state(st, 1'b0);
    wait_drain();

    // Bypass, mode toggled on later slices
    st = '{25'h1ABCDEF, 25'h0123456, 25'h1FFFFFF, 25'h0000000};
    push_directed(st);
    send_state(st, 1'b1);
    wait_drain();

    // Column-parity-even input passes through theta unchanged
    st = '{25'h0000021, 25'h0000021, 25'h0000021, 25'h0000021};
    push_directed(st);
    send_state(st, 1'b0);
    wait_drain();

    // Backpressure pattern 1,0,0,...
    ready_mode = 1;
    for (int i = 0; i < 3; i++) begin
      rand_state(st);
      m = (i == 2);
      push_model(st, m);
      send_state(st, m);
    end
    wait_drain();

    // Random states, random mode, random out_ready
    ready_mode = 2;
    for (int i = 0; i < 12; i++) begin
      rand_state(st);
      m = 1'($urandom_range(0, 1));
      push_model(st, m);
      send_state(st, m);
    end
    wait_drain();

    // Reset after exactly two output handshakes
    ready_mode = 3;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    rand_state(st);
    push_model(st, 1'b0);
    send_state(st, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midemit_popped", 32'(exp_q.size()), 32'(2));
    check("midemit_out_valid", 32'(out_valid), 32'(0));
    check("midemit_in_ready", 32'(in_ready), 32'(1));
    check("midemit_out_last", 32'(out_last), 32'(0));
    exp_q.delete();

    // Fresh state after reset
    ready_mode = 0;
    rand_state(st);
    push_model(st, 1'b0);
    send_state(st, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
